processor_stage1: RTL and testbench

Instruction fetch stage of the 18-bit pipelined processor. Drives the synchronous code memory address, pairs each returned code word with its instruction pointer, and feeds `no_operation`, `ip`, `ip_plus_one` and `code_word` to stage 2 (register/memory read). It redirects on `call_performed`/`ip_to_call` from stage 2, inserting the required bubble, and freezes while `waiting_global` is high without losing the fetched word.

---
 rtl/processor_pkg.sv | 27 ++
 rtl/perf_counter.sv | 31 +++
 rtl/processor_stage1.sv | 103 ++++++++++
 tb/tb_processor_stage1.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the 18-bit pipelined processor: widths, reset vector,
// address type and opcode constants.
package processor_pkg;

    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned WORD_W     = 18;
    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned PERF_W     = 32;

    typedef logic [ADDR_W-1:0] ip_t;

    localparam ip_t RESET_IP_DEFAULT = '0;

    // Opcode field lives in the top bits of a code word
    localparam logic [OPCODE_W-1:0] OP_NOP   = 5'h00;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 5'h01;
    localparam logic [OPCODE_W-1:0] OP_STORE = 5'h02;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 5'h03;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 5'h04;
    localparam logic [OPCODE_W-1:0] OP_AND   = 5'h05;
    localparam logic [OPCODE_W-1:0] OP_OR    = 5'h06;
    localparam logic [OPCODE_W-1:0] OP_XOR   = 5'h07;
    localparam logic [OPCODE_W-1:0] OP_JUMP  = 5'h08;
    localparam logic [OPCODE_W-1:0] OP_CALL  = 5'h09;
    localparam logic [OPCODE_W-1:0] OP_RET   = 5'h0A;

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with synchronous clear and increment enable.
module perf_counter
    import processor_pkg::*;
#(
    parameter int unsigned WIDTH = PERF_W
) (
    input  logic             clock,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/processor_stage1.sv
// Instruction fetch stage: drives code memory, aligns returned words with their IP,
// handles redirect bubbles and stalls. Optional counters: PROCESSOR_PERF_COUNTERS_EN.
module processor_stage1
    import processor_pkg::*;
#(
    parameter int unsigned           ADDR_SIZE = ADDR_W,
    parameter int unsigned           WORD_SIZE = WORD_W,
    parameter logic [ADDR_SIZE-1:0]  RESET_IP  = ADDR_SIZE'(RESET_IP_DEFAULT)
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [ADDR_SIZE-1:0] code_addr,
    input  logic [WORD_SIZE-1:0] code_data,
    input  logic                 waiting_global,
    input  logic                 call_performed,
    input  logic [ADDR_SIZE-1:0] ip_to_call,
    output logic                 no_operation,
    output logic [ADDR_SIZE-1:0] ip,
    output logic [ADDR_SIZE-1:0] ip_plus_one,
    output logic [WORD_SIZE-1:0] code_word
`ifdef PROCESSOR_PERF_COUNTERS_EN
    ,
    output logic [31:0]          perf_instr_count,
    output logic [31:0]          perf_bubble_count
`endif
);

    logic [ADDR_SIZE-1:0] pc_fetch_q,  pc_fetch_d;
    logic [ADDR_SIZE-1:0] ip_q,        ip_d;
    logic                 nop_q,       nop_d;
    logic [WORD_SIZE-1:0] hold_word_q, hold_word_d;
    logic                 held_q,      held_d;

    // Next state: stall > redirect > sequential advance (reset handled in the register)
    always_comb begin
        pc_fetch_d  = pc_fetch_q;
        ip_d        = ip_q;
        nop_d       = nop_q;
        hold_word_d = hold_word_q;
        held_d      = 1'b0;
        if (waiting_global) begin
            // Capture the word once; memory output moves on while the address is frozen
            held_d = 1'b1;
            if (!held_q) begin
                hold_word_d = code_data;
            end
        end else if (call_performed) begin
            // Word in flight belongs to the old path, so the next slot is a bubble
            pc_fetch_d = ip_to_call;
            ip_d       = pc_fetch_q;
            nop_d      = 1'b1;
        end else begin
            pc_fetch_d = pc_fetch_q + ADDR_SIZE'(1);
            ip_d       = pc_fetch_q;
            nop_d      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_fetch_q <= RESET_IP;
            ip_q       <= RESET_IP;
            nop_q      <= 1'b1;
            held_q     <= 1'b0;
        end else begin
            pc_fetch_q  <= pc_fetch_d;
            ip_q        <= ip_d;
            nop_q       <= nop_d;
            hold_word_q <= hold_word_d;
            held_q      <= held_d;
        end
    end

    assign code_addr    = pc_fetch_q;
    assign code_word    = held_q ? hold_word_q : code_data;
    assign ip           = ip_q;
    assign ip_plus_one  = ip_q + ADDR_SIZE'(1);
    assign no_operation = nop_q;

`ifdef PROCESSOR_PERF_COUNTERS_EN
    logic instr_inc;
    logic bubble_inc;

    // Only slots actually handed to stage 2 are counted; stalled cycles are not
    assign instr_inc  = !waiting_global && !nop_q;
    assign bubble_inc = !waiting_global &&  nop_q;

    perf_counter #(.WIDTH(32)) u_instr_counter (
        .clock   (clock),
        .clear_i (reset),
        .inc_i   (instr_inc),
        .count_o (perf_instr_count)
    );

    perf_counter #(.WIDTH(32)) u_bubble_counter (
        .clock   (clock),
        .clear_i (reset),
        .inc_i   (bubble_inc),
        .count_o (perf_bubble_count)
    );
`endif

endmodule

// File: tb/tb_processor_stage1.sv
// Self-checking bench for processor_stage1: table of per-cycle vectors through a
// scoreboard queue, plus a counter sequence when PROCESSOR_PERF_COUNTERS_EN is set.
module tb_processor_stage1;

    localparam int unsigned AW     = 18;
    localparam int unsigned WW     = 18;
    localparam int unsigned NVEC   = 30;

    logic          clock;
    logic          reset;
    logic [AW-1:0] code_addr;
    logic [WW-1:0] code_data;
    logic          waiting_global;
    logic          call_performed;
    logic [AW-1:0] ip_to_call;
    logic          no_operation;
    logic [AW-1:0] ip;
    logic [AW-1:0] ip_plus_one;
    logic [WW-1:0] code_word;
`ifdef PROCESSOR_PERF_COUNTERS_EN
    logic [31:0]   perf_instr_count;
    logic [31:0]   perf_bubble_count;
`endif

    int errors = 0;
    int checks = 0;

    processor_stage1 dut (
        .clock          (clock),
        .reset          (reset),
        .code_addr      (code_addr),
        .code_data      (code_data),
        .waiting_global (waiting_global),
        .call_performed (call_performed),
        .ip_to_call     (ip_to_call),
        .no_operation   (no_operation),
        .ip             (ip),
        .ip_plus_one    (ip_plus_one),
        .code_word      (code_word)
`ifdef PROCESSOR_PERF_COUNTERS_EN
        ,
        .perf_instr_count  (perf_instr_count),
        .perf_bubble_count (perf_bubble_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Code memory contents: mem[a] = a + 0x1000 (mod 2^18); synchronous read
    function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
        logic [AW-1:0] s;
        s = a + 18'h01000;
        return WW'(s);
    endfunction

    always @(posedge clock) code_data <= mem_word(code_addr);

    typedef struct {
        logic          rst;
        logic          stall;
        logic          call;
        logic [AW-1:0] tgt;
        logic          nop;
        logic [AW-1:0] eip;
        logic [AW-1:0] addr;
        logic          chk;
    } vec_t;

    typedef struct {
        int            idx;
        logic          nop;
        logic [AW-1:0] eip;
        logic [AW-1:0] eipp1;
        logic [AW-1:0] addr;
        logic          chk;
        logic [WW-1:0] word;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];

    function automatic vec_t mk(input logic rst, input logic stall, input logic call,
                                input logic [AW-1:0] tgt, input logic nop,
                                input logic [AW-1:0] eip, input logic [AW-1:0] addr,
                                input logic chk);
        vec_t v;
        v.rst = rst; v.stall = stall; v.call = call; v.tgt = tgt;
        v.nop = nop; v.eip = eip; v.addr = addr; v.chk = chk;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h, want %h", name, idx, got, want);
        end
    endtask

    initial begin
        exp_t e;
        exp_t g;

        // inputs: rst stall call tgt | expected outputs seen in that cycle: nop ip addr word-checked
        vecs[0]  = mk(0, 0, 0, 18'h0,     1, 18'h0,     18'h0,     0);
        vecs[1]  = mk(0, 0, 0, 18'h0,     0, 18'h0,     18'h1,     1);
        vecs[2]  = mk(0, 0, 0, 18'h0,     0, 18'h1,     18'h2,     1);
        vecs[3]  = mk(0, 0, 0, 18'h0,     0, 18'h2,     18'h3,     1);
        vecs[4]  = mk(0, 1, 0, 18'h0,     0, 18'h3,     18'h4,     1);
        vecs[5]  = mk(0, 1, 0, 18'h0,     0, 18'h3,     18'h4,     1);
        vecs[6]  = mk(0, 1, 1, 18'h200,   0, 18'h3,     18'h4,     1);
        vecs[7]  = mk(0, 1, 0, 18'h0,     0, 18'h3,     18'h4,     1);
        vecs[8]  = mk(0, 1, 0, 18'h0,     0, 18'h3,     18'h4,     1);
        vecs[9]  = mk(0, 0, 0, 18'h0,     0, 18'h3,     18'h4,     1);
        vecs[10] = mk(0, 0, 0, 18'h0,     0, 18'h4,     18'h5,     1);
        vecs[11] = mk(1, 0, 0, 18'h0,     0, 18'h5,     18'h6,     1);
        vecs[12] = mk(0, 0, 0, 18'h0,     1, 18'h0,     18'h0,     0);
        vecs[13] = mk(0, 0, 0, 18'h0,     0, 18'h0,     18'h1,     1);
        vecs[14] = mk(0, 0, 0, 18'h0,     0, 18'h1,     18'h2,     1);
        vecs[15] = mk(0, 0, 1, 18'h100,   0, 18'h2,     18'h3,     1);
        vecs[16] = mk(0, 0, 0, 18'h0,     1, 18'h3,     18'h100,   0);
        vecs[17] = mk(0, 0, 0, 18'h0,     0, 18'h100,   18'h101,   1);
        vecs[18] = mk(0, 1, 1, 18'h3FFFE, 0, 18'h101,   18'h102,   1);
        vecs[19] = mk(0, 0, 0, 18'h0,     0, 18'h101,   18'h102,   1);
        vecs[20] = mk(0, 0, 1, 18'h3FFFE, 0, 18'h102,   18'h103,   1);
        vecs[21] = mk(0, 0, 0, 18'h0,     1, 18'h103,   18'h3FFFE, 0);
        vecs[22] = mk(0, 0, 0, 18'h0,     0, 18'h3FFFE, 18'h3FFFF, 1);
        vecs[23] = mk(0, 0, 0, 18'h0,     0, 18'h3FFFF, 18'h0,     1);
        vecs[24] = mk(0, 0, 0, 18'h0,     0, 18'h0,     18'h1,     1);
        vecs[25] = mk(0, 0, 1, 18'h40,    0, 18'h1,     18'h2,     1);
        vecs[26] = mk(0, 1, 0, 18'h0,     1, 18'h2,     18'h40,    0);
        vecs[27] = mk(1, 1, 0, 18'h0,     1, 18'h2,     18'h40,    0);
        vecs[28] = mk(0, 0, 0, 18'h0,     1, 18'h0,     18'h0,     0);
        vecs[29] = mk(0, 0, 0, 18'h0,     0, 18'h0,     18'h1,     1);

        reset          = 1'b1;
        waiting_global = 1'b0;
        call_performed = 1'b0;
        ip_to_call     = '0;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            reset          = vecs[i].rst;
            waiting_global = vecs[i].stall;
            call_performed = vecs[i].call;
            ip_to_call     = vecs[i].tgt;
            e.idx   = i;
            e.nop   = vecs[i].nop;
            e.eip   = vecs[i].eip;
            e.eipp1 = vecs[i].eip + 18'd1;
            e.addr  = vecs[i].addr;
            e.chk   = vecs[i].chk;
            e.word  = mem_word(vecs[i].eip);
            sb.push_back(e);

            @(negedge clock);
            if (sb.size() == 0) begin
                check("scoreboard_empty", i, 32'd1, 32'd0);
            end else begin
                g = sb.pop_front();
                check("no_operation", g.idx, 32'(no_operation), 32'(g.nop));
                check("ip",           g.idx, 32'(ip),           32'(g.eip));
                check("ip_plus_one",  g.idx, 32'(ip_plus_one),  32'(g.eipp1));
                check("code_addr",    g.idx, 32'(code_addr),    32'(g.addr));
                if (g.chk) begin
                    check("code_word", g.idx, 32'(code_word), 32'(g.word));
                end
            end
            @(posedge clock);
            #1;
        end

`ifdef PROCESSOR_PERF_COUNTERS_EN
        // Ten issued instructions (with a two-cycle stall inside) and one call
        reset          = 1'b1;
        waiting_global = 1'b0;
        call_performed = 1'b0;
        ip_to_call     = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 14; c++) begin
            waiting_global = (c == 5) || (c == 6);
            call_performed = (c == 12);
            ip_to_call     = 18'h80;
            if (c == 0) begin
                @(negedge clock);
                check("perf_instr_cleared",  c, perf_instr_count,  32'd0);
                check("perf_bubble_cleared", c, perf_bubble_count, 32'd0);
            end
            @(posedge clock);
            #1;
        end
        waiting_global = 1'b0;
        call_performed = 1'b0;
        @(negedge clock);
        check("perf_instr_count",  14, perf_instr_count,  32'd10);
        check("perf_bubble_count", 14, perf_bubble_count, 32'd2);
        check("ip_after_call",     14, 32'(ip),           32'h80);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
